// File: rtl/nanci_mesh_if.sv
// Status bundle of the nanci mesh: the mesh drives it, the observer samples it.
interface nanci_mesh_if;
  logic done;

  modport master (output done);
  modport slave  (input  done);
endinterface

// File: rtl/nanci_mesh.sv
// Mesh of N processing elements that routes one packet per PE to its target
// by shearsorting the packets by address, then latching each arriving payload.

module nanci_pe #(
  parameter int N          = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 6,
  parameter int K          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_en,
  input  logic [ADDR_WIDTH-1:0] nxt_addr,
  input  logic [DATA_WIDTH-1:0] nxt_data,
  output logic [ADDR_WIDTH-1:0] pkt_addr,
  output logic [DATA_WIDTH-1:0] pkt_data
);
  localparam logic [ADDR_WIDTH-1:0] INIT_ADDR = ADDR_WIDTH'(N - 1 - K);
  localparam logic [DATA_WIDTH-1:0] INIT_DATA = DATA_WIDTH'(K);
  localparam logic [ADDR_WIDTH-1:0] MY_ADDR   = ADDR_WIDTH'(K);

  logic [ADDR_WIDTH-1:0] pkt_addr_q, pkt_addr_d;
  logic [DATA_WIDTH-1:0] pkt_data_q, pkt_data_d;

  always_comb begin
    pkt_addr_d = pkt_addr_q;
    pkt_data_d = pkt_data_q;
    if (step_en) begin
      pkt_addr_d = nxt_addr;
      pkt_data_d = nxt_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_addr_q <= INIT_ADDR;
      pkt_data_q <= INIT_DATA;
    end else begin
      pkt_addr_q <= pkt_addr_d;
      pkt_data_q <= pkt_data_d;
    end
  end

  assign pkt_addr = pkt_addr_q;
  assign pkt_data = pkt_data_q;

  // Local memory keeps capturing whenever the packet sitting here is ours.
  if (1) begin : nanci_init
    logic [DATA_WIDTH-1:0] memory;
    logic [DATA_WIDTH-1:0] memory_d;

    always_comb begin
      memory_d = memory;
      if (pkt_addr_q == MY_ADDR) memory_d = pkt_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) memory <= '0;
      else      memory <= memory_d;
    end
  end
endmodule

module nanci_mesh #(
  parameter int N           = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 6,
  parameter int SORT_CYCLES = 53
) (
  input  logic         clk,
  input  logic         rst,
  nanci_mesh_if.master bus
);
  localparam int LR    = $clog2(N) / 2;
  localparam int R     = 1 << LR;
  localparam int CW0   = $clog2(SORT_CYCLES + 1);
  // Counter always carries the phase bit, even for very short budgets.
  localparam int CNT_W = (CW0 > LR) ? CW0 : LR + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SORT_CYCLES);

  logic [CNT_W-1:0] step_q, step_d;
  logic             done_q, done_d;
  logic             step_en, row_phase, s_odd;

  logic [ADDR_WIDTH-1:0] pkt_addr [N];
  logic [DATA_WIDTH-1:0] pkt_data [N];

  always_comb begin
    step_en   = (step_q != LAST);
    step_d    = step_q;
    done_d    = done_q;
    if (step_en) step_d = step_q + 1'b1;
    if (step_d == LAST) done_d = 1'b1;
    // R is a power of two: bit LR is the phase parity, bit 0 the step parity.
    row_phase = ~step_q[LR];
    s_odd     = step_q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      done_q <= done_d;
    end
  end

  assign bus.done = done_q;

  for (genvar k = 0; k < N; k++) begin : GEN
    localparam int ROW     = k / R;
    localparam int POS     = k % R;
    localparam bit POS_ODD = (POS % 2) == 1;
    localparam bit ROW_ODD = (ROW % 2) == 1;
    localparam bit HAS_RHI = POS < R - 1;
    localparam bit HAS_RLO = POS > 0;
    localparam bit HAS_CHI = ROW < R - 1;
    localparam bit HAS_CLO = ROW > 0;
    localparam int RHI     = HAS_RHI ? k + 1 : k;
    localparam int RLO     = HAS_RLO ? k - 1 : k;
    // Snake rows alternate direction, so the vertical neighbour mirrors POS.
    localparam int CHI     = HAS_CHI ? (ROW + 1) * R + (R - 1 - POS) : k;
    localparam int CLO     = HAS_CLO ? (ROW - 1) * R + (R - 1 - POS) : k;

    logic                  take;
    logic [ADDR_WIDTH-1:0] par_addr, nxt_addr;
    logic [DATA_WIDTH-1:0] par_data, nxt_data;

    always_comb begin
      take     = 1'b0;
      par_addr = pkt_addr[k];
      par_data = pkt_data[k];
      if (row_phase) begin
        if (POS_ODD == s_odd) begin
          if (HAS_RHI) begin
            par_addr = pkt_addr[RHI];
            par_data = pkt_data[RHI];
            take     = pkt_addr[RHI] < pkt_addr[k];
          end
        end else if (HAS_RLO) begin
          par_addr = pkt_addr[RLO];
          par_data = pkt_data[RLO];
          take     = pkt_addr[RLO] > pkt_addr[k];
        end
      end else begin
        if (ROW_ODD == s_odd) begin
          if (HAS_CHI) begin
            par_addr = pkt_addr[CHI];
            par_data = pkt_data[CHI];
            take     = pkt_addr[CHI] < pkt_addr[k];
          end
        end else if (HAS_CLO) begin
          par_addr = pkt_addr[CLO];
          par_data = pkt_data[CLO];
          take     = pkt_addr[CLO] > pkt_addr[k];
        end
      end
      nxt_addr = take ? par_addr : pkt_addr[k];
      nxt_data = take ? par_data : pkt_data[k];
    end

    if (1) begin : GENIF
      nanci_pe #(
        .N(N), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .K(k)
      ) PE (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step_en),
        .nxt_addr (nxt_addr),
        .nxt_data (nxt_data),
        .pkt_addr (pkt_addr[k]),
        .pkt_data (pkt_data[k])
      );
    end
  end
endmodule

// File: tb/tb_nanci_mesh.sv
// Bench for nanci_mesh: four configurations run side by side against a
// grid-level shearsort model; reset timing and checkpoints are randomized.
module tb_nanci_mesh;
  logic clk;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  int    cfg_n  [4] = '{64, 64, 16, 64};
  int    cfg_sc [4] = '{53, 56, 20, 8};
  string cfg_nm [4] = '{"A", "B", "C", "D"};

  nanci_mesh_if ifA ();
  nanci_mesh_if ifB ();
  nanci_mesh_if ifC ();
  nanci_mesh_if ifD ();

  nanci_mesh #(.N(64), .ADDR_WIDTH(6), .DATA_WIDTH(6), .SORT_CYCLES(53))
    dA (.clk(clk), .rst(rst), .bus(ifA));
  nanci_mesh #(.N(64), .ADDR_WIDTH(6), .DATA_WIDTH(6), .SORT_CYCLES(56))
    dB (.clk(clk), .rst(rst), .bus(ifB));
  nanci_mesh #(.N(16), .ADDR_WIDTH(4), .DATA_WIDTH(4), .SORT_CYCLES(20))
    dC (.clk(clk), .rst(rst), .bus(ifC));
  nanci_mesh #(.N(64), .ADDR_WIDTH(6), .DATA_WIDTH(6), .SORT_CYCLES(8))
    dD (.clk(clk), .rst(rst), .bus(ifD));

  logic [5:0] memA [64], addrA [64], dataA [64];
  logic [5:0] memB [64], addrB [64], dataB [64];
  logic [3:0] memC [16], addrC [16], dataC [16];
  logic [5:0] memD [64], addrD [64], dataD [64];

  for (genvar g = 0; g < 64; g++) begin : OBS64
    assign memA[g]  = dA.GEN[g].GENIF.PE.nanci_init.memory;
    assign addrA[g] = dA.GEN[g].GENIF.PE.pkt_addr_q;
    assign dataA[g] = dA.GEN[g].GENIF.PE.pkt_data_q;
    assign memB[g]  = dB.GEN[g].GENIF.PE.nanci_init.memory;
    assign addrB[g] = dB.GEN[g].GENIF.PE.pkt_addr_q;
    assign dataB[g] = dB.GEN[g].GENIF.PE.pkt_data_q;
    assign memD[g]  = dD.GEN[g].GENIF.PE.nanci_init.memory;
    assign addrD[g] = dD.GEN[g].GENIF.PE.pkt_addr_q;
    assign dataD[g] = dD.GEN[g].GENIF.PE.pkt_data_q;
  end
  for (genvar g = 0; g < 16; g++) begin : OBS16
    assign memC[g]  = dC.GEN[g].GENIF.PE.nanci_init.memory;
    assign addrC[g] = dC.GEN[g].GENIF.PE.pkt_addr_q;
    assign dataC[g] = dC.GEN[g].GENIF.PE.pkt_data_q;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // sel: 0 = memory, 1 = packet addr, 2 = packet data
  function automatic int obs(input int id, input int sel, input int k);
    case (id)
      0:       return sel == 0 ? int'(memA[k]) : sel == 1 ? int'(addrA[k]) : int'(dataA[k]);
      1:       return sel == 0 ? int'(memB[k]) : sel == 1 ? int'(addrB[k]) : int'(dataB[k]);
      2:       return sel == 0 ? int'(memC[k]) : sel == 1 ? int'(addrC[k]) : int'(dataC[k]);
      default: return sel == 0 ? int'(memD[k]) : sel == 1 ? int'(addrD[k]) : int'(dataD[k]);
    endcase
  endfunction

  function automatic int obs_done(input int id);
    case (id)
      0:       return int'(ifA.done);
      1:       return int'(ifB.done);
      2:       return int'(ifC.done);
      default: return int'(ifD.done);
    endcase
  endfunction

  // Reference model: packets live on an R x R grid; grid index k is laid out in snake order.
  int m_mem [64], m_addr [64], m_data [64];

  function automatic int snake_col(input int r, input int j, input int rr);
    return (r % 2 == 0) ? j : rr - 1 - j;
  endfunction

  task automatic model_run(input int n, input int sc, input int cyc);
    int rr, r, c, c0, c1, s, tmp;
    int ga [8][8];
    int gd [8][8];
    rr = 1;
    while (rr * rr < n) rr = rr * 2;
    for (int k = 0; k < 64; k++) m_mem[k] = 0;
    for (int k = 0; k < n; k++) begin
      r = k / rr;
      ga[r][snake_col(r, k % rr, rr)] = n - 1 - k;
      gd[r][snake_col(r, k % rr, rr)] = k;
    end
    for (int e = 0; e < cyc; e++) begin
      for (int rw = 0; rw < rr; rw++)
        for (int cl = 0; cl < rr; cl++)
          if (ga[rw][cl] == rw * rr + snake_col(rw, cl, rr)) m_mem[rw * rr + snake_col(rw, cl, rr)] = gd[rw][cl];
      if (e < sc) begin
        s = e % rr;
        if ((e / rr) % 2 == 0) begin
          for (int rw = 0; rw < rr; rw++)
            for (int j = s % 2; j + 1 < rr; j += 2) begin
              c0 = snake_col(rw, j, rr);
              c1 = snake_col(rw, j + 1, rr);
              if (ga[rw][c0] > ga[rw][c1]) begin
                tmp = ga[rw][c0]; ga[rw][c0] = ga[rw][c1]; ga[rw][c1] = tmp;
                tmp = gd[rw][c0]; gd[rw][c0] = gd[rw][c1]; gd[rw][c1] = tmp;
              end
            end
        end else begin
          for (int cl = 0; cl < rr; cl++)
            for (int rw = s % 2; rw + 1 < rr; rw += 2)
              if (ga[rw][cl] > ga[rw + 1][cl]) begin
                tmp = ga[rw][cl]; ga[rw][cl] = ga[rw + 1][cl]; ga[rw + 1][cl] = tmp;
                tmp = gd[rw][cl]; gd[rw][cl] = gd[rw + 1][cl]; gd[rw + 1][cl] = tmp;
              end
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      r = k / rr;
      c = snake_col(r, k % rr, rr);
      m_addr[k] = ga[r][c];
      m_data[k] = gd[r][c];
    end
  endtask

  task automatic compare_all(input int id, input int cyc);
    model_run(cfg_n[id], cfg_sc[id], cyc);
    for (int k = 0; k < cfg_n[id]; k++) begin
      chk($sformatf("%s@%0d mem[%0d]", cfg_nm[id], cyc, k), obs(id, 0, k), m_mem[k]);
      chk($sformatf("%s@%0d addr[%0d]", cfg_nm[id], cyc, k), obs(id, 1, k), m_addr[k]);
      chk($sformatf("%s@%0d data[%0d]", cfg_nm[id], cyc, k), obs(id, 2, k), m_data[k]);
    end
  endtask

  task automatic check_reset();
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("%s reset done", cfg_nm[id]), obs_done(id), 0);
      compare_all(id, 0);
    end
  endtask

  task automatic run_cycles(input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      for (int id = 0; id < 4; id++)
        chk($sformatf("%s@%0d done", cfg_nm[id], n), obs_done(id), (n >= cfg_sc[id]) ? 1 : 0);
      if (n % 7 == 0 || $urandom_range(0, 9) == 0 || n == ncyc || n == 8 || n == 9 ||
          n == 20 || n == 21 || n == 24 || (n >= 52 && n <= 57))
        for (int id = 0; id < 4; id++) compare_all(id, n);
    end
  endtask

  task automatic check_final();
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("A final mem[%0d]", k), obs(0, 0, k), 63 - k);
      chk($sformatf("B final mem[%0d]", k), obs(1, 0, k), 63 - k);
    end
    for (int k = 0; k < 16; k++)
      chk($sformatf("C final mem[%0d]", k), obs(2, 0, k), 15 - k);
  endtask

  initial begin
    int cut;
    rst = 1'b0;
    repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    check_reset();
    rst = 1'b1;
    run_cycles(100);
    check_final();

    // Fresh run, then an asynchronous reset dropped in mid-sort.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cut = 10 + $urandom_range(0, 4);
    run_cycles(cut);
    #2 rst = 1'b0;
    #1 check_reset();
    @(negedge clk);
    check_reset();
    rst = 1'b1;
    run_cycles(100);
    check_final();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
